// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake bundle for seq_shift_add_multiplier; MULT_ACCUM_EN adds the acc request bit.
interface seq_shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

`ifdef MULT_ACCUM_EN
  logic                 acc;

  modport master (
    output in_valid, a, b, acc, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, acc, out_ready,
    output in_ready, out_valid, product, busy
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
`endif
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add unsigned multiplier, one partial product per clock, valid/ready on both sides.
// Optional MULT_ACCUM_EN: acc=1 at accept seeds the accumulator with the previous product.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_shift_add_multiplier_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic [PW-1:0]    p_add;
  logic             in_ready_c;

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready_c = (state_q == IDLE) && !rst;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    p_add     = mplier_q[0] ? (p_q + mcand_q) : p_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          mcand_d  = PW'(bus.a);
          mplier_d = bus.b;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = RUN;
`ifdef MULT_ACCUM_EN
          p_d      = bus.acc ? product_q : '0;
`else
          p_d      = '0;
`endif
        end
      end
      RUN: begin
        p_d      = p_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // Fixed latency: the last step commits straight to the result register
        if (cnt_q == CNT_W'(1)) begin
          product_d = p_add;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.busy      = (state_q == RUN) && !rst;
  assign bus.product   = product_q;

endmodule
